// File: rtl/dcmac_0_reset_sequencer.sv
// Ordered GT/core reset bring-up for the DCMAC: hold, release GT, wait for synchronized GT done, settle, run.
// Optional timeout retries are built only when DCMAC_0_RESET_SEQ_RETRY_EN is defined.
module dcmac_0_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SETTLE_CYCLES  = 8,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst_req,
    input  logic       gt_reset_done_async,
    output logic       gt_reset,
    output logic       core_reset,
    output logic       seq_done,
    output logic       seq_fail,
    output logic [1:0] retry_count
);

    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_GT,
        ST_SETTLE,
        ST_RUN,
        ST_FAIL
    } state_t;

    state_t r_state;
    state_t w_state_next;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

    logic                w_done_s;
    logic                w_stay;
    logic                w_retry_ok;
    logic [HOLD_W-1:0]   r_hold_cnt;
    logic [TMO_W-1:0]    r_wait_cnt;
    logic [SETTLE_W-1:0] r_settle_cnt;
    logic                r_gt_reset;
    logic                r_core_reset;
    logic                r_seq_done;
    logic                r_seq_fail;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], gt_reset_done_async};
        end
    end

    assign w_done_s = r_sync[SYNC_STAGES-1];

`ifdef DCMAC_0_RESET_SEQ_RETRY_EN
    logic [1:0] r_retry;
    logic       w_retry_inc;

    assign w_retry_ok  = (r_retry < RETRY_LIMIT);
    // WAIT_GT can only fall back to HOLD through a retried timeout or a restart request.
    assign w_retry_inc = (r_state == ST_WAIT_GT) && (w_state_next == ST_HOLD) && !rst_req;

    always_ff @(posedge clk) begin
        if (reset || rst_req) begin
            r_retry <= 2'd0;
        end else if (w_retry_inc) begin
            r_retry <= r_retry + 2'd1;
        end
    end

    assign retry_count = r_retry;
`else
    // Never true for a legal MAX_RETRIES, so every timeout lands in FAIL.
    assign w_retry_ok  = (RETRY_LIMIT == 2'd0);
    assign retry_count = 2'd0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD: begin
                if (r_hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) w_state_next = ST_WAIT_GT;
            end
            ST_WAIT_GT: begin
                if (!w_done_s && (r_wait_cnt == TMO_W'(TIMEOUT_CYCLES - 1))) begin
                    w_state_next = w_retry_ok ? ST_HOLD : ST_FAIL;
                end else if (w_done_s) begin
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!w_done_s) begin
                    w_state_next = ST_HOLD;
                end else if (r_settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!w_done_s) w_state_next = ST_HOLD;
            end
            ST_FAIL: w_state_next = ST_FAIL;
            default: w_state_next = ST_HOLD;
        endcase
        if (rst_req) w_state_next = ST_HOLD;
    end

    assign w_stay = (w_state_next == r_state) && !rst_req;

    // Each counter runs only while its state persists, so it is zero on every entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt   <= '0;
            r_wait_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            if (w_stay && (r_state == ST_HOLD)) begin
                if (r_hold_cnt != HOLD_W'(HOLD_CYCLES)) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end else begin
                r_hold_cnt <= '0;
            end
            if (w_stay && (r_state == ST_WAIT_GT)) begin
                if (r_wait_cnt != TMO_W'(TIMEOUT_CYCLES)) r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_stay && (r_state == ST_SETTLE)) begin
                if (r_settle_cnt != SETTLE_W'(SETTLE_CYCLES)) r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
            end else begin
                r_settle_cnt <= '0;
            end
        end
    end

    // Outputs decode the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_HOLD;
            r_gt_reset   <= 1'b1;
            r_core_reset <= 1'b1;
            r_seq_done   <= 1'b0;
            r_seq_fail   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_gt_reset   <= (w_state_next == ST_HOLD) || (w_state_next == ST_FAIL);
            r_core_reset <= (w_state_next != ST_RUN);
            r_seq_done   <= (w_state_next == ST_RUN);
            r_seq_fail   <= (w_state_next == ST_FAIL);
        end
    end

    assign gt_reset   = r_gt_reset;
    assign core_reset = r_core_reset;
    assign seq_done   = r_seq_done;
    assign seq_fail   = r_seq_fail;

endmodule

// File: tb/tb_dcmac_0_reset_sequencer.sv
// Scenario bench for dcmac_0_reset_sequencer; expectations come from the sequence timing rules with randomized delays.
module tb_dcmac_0_reset_sequencer;

    localparam int HOLD   = 16;
    localparam int TMO    = 1024;
    localparam int SETTLE = 8;
    localparam int MAXR   = 3;
    localparam int SYNC   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst_req = 1'b0;
    logic       done_async = 1'b0;
    logic       gt_reset;
    logic       core_reset;
    logic       seq_done;
    logic       seq_fail;
    logic [1:0] retry_count;

    int vectors = 0;
    int miscompares = 0;
    int m_retry = 0;

    dcmac_0_reset_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .SETTLE_CYCLES (SETTLE),
        .MAX_RETRIES   (MAXR),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .rst_req            (rst_req),
        .gt_reset_done_async(done_async),
        .gt_reset           (gt_reset),
        .core_reset         (core_reset),
        .seq_done           (seq_done),
        .seq_fail           (seq_fail),
        .retry_count        (retry_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int w);
        case (w)
            0:       return gt_reset;
            1:       return core_reset;
            2:       return seq_done;
            default: return seq_fail;
        endcase
    endfunction

    // Number of edges until the chosen output takes value v; -1 if the bound expires.
    task automatic steps_until(input int w, input logic v, input int bound, output int n);
        n = -1;
        for (int i = 1; i <= bound; i++) begin
            step();
            if (sel(w) === v) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1; rst_req = 1'b0; done_async = 1'b0;
        repeat (4) step();
        vectors++;
        if ({gt_reset, core_reset, seq_done, seq_fail, retry_count} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_values: got %b expected %b",
                     {gt_reset, core_reset, seq_done, seq_fail, retry_count}, 6'b110000);
        end
        reset = 1'b0;
        steps_until(0, 1'b0, 200, n);
        vectors++;
        if (n !== HOLD) begin
            miscompares++;
            $display("FAIL reset_hold_len: got %0d expected %0d", n, HOLD);
        end
    endtask

    // Entered just after GT reset has fallen; raises done after a delay and expects RUN.
    task automatic test_bringup(input int delay);
        int n;
        repeat (delay) step();
        vectors++;
        if ({gt_reset, core_reset} !== 2'b01) begin
            miscompares++;
            $display("FAIL wait_gt_levels: got gt=%b core=%b expected gt=0 core=1", gt_reset, core_reset);
        end
        done_async = 1'b1;
        steps_until(1, 1'b0, 200, n);
        vectors++;
        if (n - 1 !== SYNC + SETTLE) begin
            miscompares++;
            $display("FAIL core_release_latency: got %0d expected %0d", n - 1, SYNC + SETTLE);
        end
        vectors++;
        if ({seq_done, gt_reset, seq_fail} !== 3'b100 || int'(retry_count) !== m_retry) begin
            miscompares++;
            $display("FAIL run_outputs: got done=%b gt=%b fail=%b retry=%0d expected done=1 gt=0 fail=0 retry=%0d",
                     seq_done, gt_reset, seq_fail, retry_count, m_retry);
        end
    endtask

    task automatic test_loss_of_lock();
        int n;
        repeat ($urandom_range(1, 30)) step();
        done_async = 1'b0;
        steps_until(0, 1'b1, 50, n);
        vectors++;
        if (n !== SYNC + 1) begin
            miscompares++;
            $display("FAIL lock_loss_latency: got %0d expected %0d", n, SYNC + 1);
        end
        vectors++;
        if ({core_reset, seq_done} !== 2'b10 || int'(retry_count) !== m_retry) begin
            miscompares++;
            $display("FAIL lock_loss_outputs: got core=%b done=%b retry=%0d expected core=1 done=0 retry=%0d",
                     core_reset, seq_done, retry_count, m_retry);
        end
        steps_until(0, 1'b0, 200, n);
        vectors++;
        if (n !== HOLD) begin
            miscompares++;
            $display("FAIL relock_hold_len: got %0d expected %0d", n, HOLD);
        end
        test_bringup($urandom_range(0, 60));
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) test_loss_of_lock();
    endtask

    task automatic test_timeout();
        int n;
        int windows;
`ifdef DCMAC_0_RESET_SEQ_RETRY_EN
        windows = MAXR + 1;
`else
        windows = 1;
`endif
        done_async = 1'b0;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        m_retry = 0;
        for (int w = 0; w < windows; w++) begin
            steps_until(0, 1'b0, 200, n);
            vectors++;
            if (n !== HOLD) begin
                miscompares++;
                $display("FAIL timeout_hold_len[%0d]: got %0d expected %0d", w, n, HOLD);
            end
            steps_until(0, 1'b1, TMO + 50, n);
            vectors++;
            if (n !== TMO) begin
                miscompares++;
                $display("FAIL timeout_window[%0d]: got %0d expected %0d", w, n, TMO);
            end
            if (w < windows - 1) begin
                m_retry++;
                vectors++;
                if (int'(retry_count) !== m_retry || seq_fail !== 1'b0) begin
                    miscompares++;
                    $display("FAIL retry_step[%0d]: got retry=%0d fail=%b expected retry=%0d fail=0",
                             w, retry_count, seq_fail, m_retry);
                end
            end
        end
        vectors++;
        if ({seq_fail, core_reset, seq_done} !== 3'b110 || int'(retry_count) !== m_retry) begin
            miscompares++;
            $display("FAIL fail_entry: got fail=%b core=%b done=%b retry=%0d expected fail=1 core=1 done=0 retry=%0d",
                     seq_fail, core_reset, seq_done, retry_count, m_retry);
        end
        repeat ($urandom_range(20, 60)) step();
        vectors++;
        if ({seq_fail, gt_reset} !== 2'b11) begin
            miscompares++;
            $display("FAIL fail_terminal: got fail=%b gt=%b expected fail=1 gt=1", seq_fail, gt_reset);
        end
    endtask

    task automatic test_fail_recovery();
        int n;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        m_retry = 0;
        vectors++;
        if ({gt_reset, core_reset, seq_done, seq_fail, retry_count} !== 6'b110000) begin
            miscompares++;
            $display("FAIL recovery_values: got %b expected %b",
                     {gt_reset, core_reset, seq_done, seq_fail, retry_count}, 6'b110000);
        end
        steps_until(0, 1'b0, 200, n);
        vectors++;
        if (n !== HOLD) begin
            miscompares++;
            $display("FAIL recovery_hold_len: got %0d expected %0d", n, HOLD);
        end
        test_bringup($urandom_range(0, 60));
    endtask

    task automatic test_reset_mid_settle();
        int n;
        done_async = 1'b0;
        steps_until(0, 1'b1, 50, n);
        steps_until(0, 1'b0, 200, n);
        done_async = 1'b1;
        repeat (1 + SYNC + int'($urandom_range(0, SETTLE - 2))) step();
        vectors++;
        if ({gt_reset, core_reset} !== 2'b01) begin
            miscompares++;
            $display("FAIL in_settle: got gt=%b core=%b expected gt=0 core=1", gt_reset, core_reset);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_retry = 0;
        vectors++;
        if ({gt_reset, core_reset, seq_done, seq_fail, retry_count} !== 6'b110000) begin
            miscompares++;
            $display("FAIL settle_reset_values: got %b expected %b",
                     {gt_reset, core_reset, seq_done, seq_fail, retry_count}, 6'b110000);
        end
        steps_until(0, 1'b0, 200, n);
        vectors++;
        if (n !== HOLD) begin
            miscompares++;
            $display("FAIL settle_reset_hold_len: got %0d expected %0d", n, HOLD);
        end
        // Done is already synchronized when WAIT_GT is entered, so SETTLE starts one edge later.
        steps_until(1, 1'b0, 200, n);
        vectors++;
        if (n !== SETTLE + 1 || seq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL settle_reset_rerun: got %0d done=%b expected %0d done=1", n, seq_done, SETTLE + 1);
        end
    endtask

    task automatic test_simultaneous();
        int n;
        int k;
        done_async = 1'b0;
        rst_req = 1'b1;
        step();
        rst_req = 1'b0;
        steps_until(0, 1'b0, 200, n);
        repeat ($urandom_range(0, 40)) step();
        done_async = 1'b1;
        repeat (SYNC) step();
        rst_req = 1'b1;
        step();
        vectors++;
        if ({gt_reset, core_reset, seq_done} !== 3'b110) begin
            miscompares++;
            $display("FAIL simultaneous_hold: got gt=%b core=%b done=%b expected gt=1 core=1 done=0",
                     gt_reset, core_reset, seq_done);
        end
        k = $urandom_range(1, 5);
        for (int i = 0; i < k; i++) begin
            step();
            vectors++;
            if ({gt_reset, core_reset} !== 2'b11) begin
                miscompares++;
                $display("FAIL rst_req_held[%0d]: got gt=%b core=%b expected gt=1 core=1", i, gt_reset, core_reset);
            end
        end
        rst_req = 1'b0;
        steps_until(0, 1'b0, 200, n);
        vectors++;
        if (n !== HOLD) begin
            miscompares++;
            $display("FAIL simultaneous_hold_len: got %0d expected %0d", n, HOLD);
        end
        steps_until(1, 1'b0, 200, n);
        vectors++;
        if (n !== SETTLE + 1 || seq_done !== 1'b1) begin
            miscompares++;
            $display("FAIL simultaneous_rerun: got %0d done=%b expected %0d done=1", n, seq_done, SETTLE + 1);
        end
    endtask

    initial begin
        test_reset();
        test_bringup(20);
        test_loss_of_lock();
        test_back_to_back();
        test_timeout();
        test_fail_recovery();
        test_reset_mid_settle();
        test_simultaneous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
